// File: rtl/reaction_timer_multi.sv
// reaction_timer_multi
//   Multi-player reaction timer. A start press arms a random pre-GO delay;
//   when it expires the GO light turns on and a 4-digit BCD millisecond
//   counter runs until the first player hits their react button. A press
//   before GO is a false start. The fastest non-timeout time is kept as best.
//
// Ports
//   clk          system clock, all flops rising-edge
//   rst_n        asynchronous active-low reset
//   start_btn    raw start button (active-high, asynchronous)
//   react_btn    raw per-player react buttons (active-high, asynchronous)
//   show_best    in IDLE, selects the best time instead of 0000 on the display
//   led          GO light
//   seg          active-low segments a..g on bits 0..6
//   an           active-low one-hot digit enables, an[0] = ones digit
//   winner       one-hot round winner (all zero on timeout / no result)
//   false_start  high while in FOUL
module reaction_timer_multi #(
  parameter int          NUM_PLAYERS  = 2,
  parameter int          TICK_DIV     = 1000,
  parameter int          SCAN_DIV     = 250,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] DELAY_MASK   = 16'h07FF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_btn,
  input  logic [NUM_PLAYERS-1:0] react_btn,
  input  logic                   show_best,
  output logic                   led,
  output logic [6:0]             seg,
  output logic [3:0]             an,
  output logic [NUM_PLAYERS-1:0] winner,
  output logic                   false_start
);

  localparam int NB     = NUM_PLAYERS + 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {IDLE, WAIT, GO, DONE, FOUL} state_t;

  // Active-low glyphs, bit 0 = segment a.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Ripple-carry increment of a 4-digit packed BCD value.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Button conditioning: bit 0 is start, bits NB-1:1 are the react buttons.
  // press_q is registered so the pulse appears on the 3rd edge after the
  // raw input rises.
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NB-1:0] prev_q, prev_d, press_q, press_d;

  logic                   start_pulse;
  logic [NUM_PLAYERS-1:0] react_pulse;
  logic [NUM_PLAYERS-1:0] react_first;

  logic [15:0]       lfsr_q, lfsr_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic              tick;

  state_t                 state_q, state_d;
  logic [31:0]            delay_q, delay_d, delay_load;
  logic [15:0]            time_q, time_d;
  logic [15:0]            best_q, best_d;
  logic [NUM_PLAYERS-1:0] winner_q, winner_d;

  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;
  logic [15:0]       disp_val;
  logic [3:0]        disp_nib;

  assign btn_raw     = {react_btn, start_btn};
  assign start_pulse = press_q[0];
  assign react_pulse = press_q[NB-1:1];
  // Two's-complement trick isolates the lowest set bit: lowest index wins ties.
  assign react_first = react_pulse & (~react_pulse + NUM_PLAYERS'(1));
  assign tick        = (presc_q == TICK_W'(TICK_DIV - 1));
  assign delay_load  = 32'(MIN_DELAY_MS) + {16'h0000, lfsr_q & DELAY_MASK};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = sync2_q & ~prev_q;
    // Fibonacci taps 16,14,13,11 (bits 15,13,12,10).
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Round FSM; react has priority over a coincident tick so the frozen
  // time is the value shown when the winning pulse was seen.
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    time_d   = time_q;
    best_d   = best_q;
    winner_d = winner_q;
    case (state_q)
      IDLE, DONE, FOUL: begin
        if (start_pulse) begin
          state_d  = WAIT;
          delay_d  = delay_load;
          winner_d = '0;
        end
      end
      WAIT: begin
        if (|react_pulse) begin
          state_d  = FOUL;
          winner_d = react_first;
        end else if (tick) begin
          if (delay_q <= 32'd1) begin
            state_d = GO;
            delay_d = '0;
            time_d  = '0;
          end else begin
            delay_d = delay_q - 32'd1;
          end
        end
      end
      GO: begin
        if (|react_pulse) begin
          state_d  = DONE;
          winner_d = react_first;
          // Packed BCD orders the same as its binary reading.
          if (time_q < best_q) begin
            best_d = time_q;
          end
        end else if (tick) begin
          if (time_q == 16'h9999) begin
            state_d  = DONE;
            winner_d = '0;
          end else begin
            time_d = bcd_inc(time_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Free-running ms prescaler, realigned on GO entry so the first count
  // lands exactly one full tick period after the light comes on.
  always_comb begin
    presc_d = tick ? '0 : presc_q + TICK_W'(1);
    if (state_d == GO && state_q != GO) begin
      presc_d = '0;
    end
  end

  // Display scan and content selection.
  always_comb begin
    scan_d  = (scan_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_q + SCAN_W'(1);
    digit_d = (scan_q == SCAN_W'(SCAN_DIV - 1)) ? digit_q + 2'd1 : digit_q;
    case (state_q)
      IDLE:     disp_val = show_best ? best_q : 16'h0000;
      GO, DONE: disp_val = time_q;
      default:  disp_val = 16'h0000;
    endcase
    disp_nib = disp_val[{digit_q, 2'b00} +: 4];
    case (state_q)
      WAIT:    seg_d = 7'h7F;
      FOUL:    seg_d = 7'b0111111;
      default: seg_d = glyph(disp_nib);
    endcase
    an_d = ~(4'b0001 << digit_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      press_q  <= '0;
      lfsr_q   <= 16'hACE1;
      presc_q  <= '0;
      state_q  <= IDLE;
      delay_q  <= '0;
      time_q   <= 16'h0000;
      best_q   <= 16'h9999;
      winner_q <= '0;
      scan_q   <= '0;
      digit_q  <= 2'd0;
      seg_q    <= 7'b1000000;
      an_q     <= 4'b1110;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      press_q  <= press_d;
      lfsr_q   <= lfsr_d;
      presc_q  <= presc_d;
      state_q  <= state_d;
      delay_q  <= delay_d;
      time_q   <= time_d;
      best_q   <= best_d;
      winner_q <= winner_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign led         = (state_q == GO);
  assign false_start = (state_q == FOUL);
  assign winner      = winner_q;
  assign seg         = seg_q;
  assign an          = an_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Scoreboard bench for reaction_timer_multi with small dividers.
module tb_reaction_timer_multi;
  localparam int          NP   = 2;
  localparam int          TD   = 4;
  localparam int          SD   = 2;
  localparam int          MIND = 2;
  localparam logic [15:0] DM   = 16'h0003;

  logic          clk = 1'b0;
  logic          rstN;
  logic          startBtn;
  logic [NP-1:0] reactBtn;
  logic          showBest;
  logic          led;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic [NP-1:0] winner;
  logic          falseStart;

  int checks = 0;
  int errors = 0;
  bit monitorEn = 1'b0;
  int modelBest = 9999;

  typedef struct {
    bit foul;
    int win;
    int timeVal;
    int best;
  } expT;
  expT expQ[$];

  reaction_timer_multi #(
    .NUM_PLAYERS(NP), .TICK_DIV(TD), .SCAN_DIV(SD),
    .MIN_DELAY_MS(MIND), .DELAY_MASK(DM)
  ) dut (
    .clk(clk), .rst_n(rstN), .start_btn(startBtn), .react_btn(reactBtn),
    .show_best(showBest), .led(led), .seg(seg), .an(an),
    .winner(winner), .false_start(falseStart)
  );

  always #5 clk = ~clk;

  // Glyph -> digit: 0..9, 10 = dash, 11 = blank, 15 = unknown.
  function automatic int decodeSeg(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      7'b0111111: return 10;
      7'h7F:      return 11;
      default:    return 15;
    endcase
  endfunction

  function automatic int bcdToInt(input logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int lowestWinner(input int mask);
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) return (1 << i);
    end
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Scans 8 negedges and returns the shown number, -1 for four dashes,
  // -2 for anything else, -3 if some digit never got enabled.
  task automatic readDisplay(output int value);
    int dig[4];
    bit seen[4];
    int k;
    bit allDash;
    bit allNum;
    for (int i = 0; i < 4; i++) begin
      dig[i]  = 15;
      seen[i] = 1'b0;
    end
    repeat (8) begin
      @(negedge clk);
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        default: k = -1;
      endcase
      if (k >= 0) begin
        dig[k]  = decodeSeg(seg);
        seen[k] = 1'b1;
      end
    end
    allDash = 1'b1;
    allNum  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dig[i] != 10) allDash = 1'b0;
      if (dig[i] > 9) allNum = 1'b0;
    end
    if (!(seen[0] && seen[1] && seen[2] && seen[3])) value = -3;
    else if (allDash) value = -1;
    else if (allNum) value = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
    else value = -2;
  endtask

  // Monitor: a round result is presented when GO ends or FOUL begins.
  initial begin
    bit prevLed;
    bit prevFs;
    expT e;
    int v;
    prevLed = 1'b0;
    prevFs  = 1'b0;
    forever begin
      @(negedge clk);
      if (monitorEn && ((prevLed && !led) || (!prevFs && falseStart))) begin
        checkOutput("pendingExpect", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("winner", int'(winner), e.win);
          checkOutput("falseStart", int'(falseStart), int'(e.foul));
          checkOutput("best", bcdToInt(dut.best_q), e.best);
          @(negedge clk);
          @(negedge clk);
          readDisplay(v);
          checkOutput("display", v, e.foul ? -1 : e.timeVal);
        end
      end
      prevLed = led;
      prevFs  = falseStart;
    end
  end

  // kind 0: GO round pressed n cycles after led; 1: false start; 2: timeout.
  task automatic applyStimulus(input int kind, input int n, input int mask, input bit spurious);
    expT e;
    bit ok;
    @(negedge clk);
    startBtn = 1'b1;
    if (kind == 1) begin
      e.foul = 1'b1; e.win = lowestWinner(mask); e.timeVal = 0; e.best = modelBest;
      expQ.push_back(e);
      @(negedge clk);
      reactBtn = NP'(mask);
      repeat (4) @(negedge clk);
      startBtn = 1'b0;
      reactBtn = '0;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        if (falseStart) ok = 1'b1;
        else @(negedge clk);
      end
      checkOutput("foulSeen", int'(ok), 1);
      repeat (30) @(negedge clk);
      return;
    end
    repeat (3) @(negedge clk);
    startBtn = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (led) ok = 1'b1;
    end
    checkOutput("ledRose", int'(ok), 1);
    if (!ok) return;
    if (kind == 2) begin
      e.foul = 1'b0; e.win = 0; e.timeVal = 9999; e.best = modelBest;
      expQ.push_back(e);
      ok = 1'b0;
      for (int i = 0; i < 41000 && !ok; i++) begin
        @(negedge clk);
        if (!led) ok = 1'b1;
      end
      checkOutput("timeoutSeen", int'(ok), 1);
      repeat (30) @(negedge clk);
      return;
    end
    e.foul = 1'b0;
    e.win = lowestWinner(mask);
    e.timeVal = (n + 3) / TD;
    if (e.timeVal < modelBest) modelBest = e.timeVal;
    e.best = modelBest;
    expQ.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (spurious && i == 0) startBtn = 1'b1;
      if (i == 2) startBtn = 1'b0;
      @(negedge clk);
    end
    startBtn = 1'b0;
    reactBtn = NP'(mask);
    repeat (4) @(negedge clk);
    reactBtn = '0;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (!led) ok = 1'b1;
      else @(negedge clk);
    end
    checkOutput("doneSeen", int'(ok), 1);
    repeat (30) @(negedge clk);
  endtask

  initial begin
    int v;
    rstN     = 1'b0;
    startBtn = 1'b0;
    reactBtn = '0;
    showBest = 1'b0;
    #12;
    checkOutput("rstLed", int'(led), 0);
    checkOutput("rstWinner", int'(winner), 0);
    checkOutput("rstFalseStart", int'(falseStart), 0);
    checkOutput("rstSeg", int'(seg), int'(7'b1000000));
    checkOutput("rstAn", int'(an), int'(4'b1110));
    @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    readDisplay(v);
    checkOutput("idleZero", v, 0);
    showBest = 1'b1;
    repeat (2) @(negedge clk);
    readDisplay(v);
    checkOutput("idleBestInit", v, 9999);
    showBest = 1'b0;
    monitorEn = 1'b1;

    applyStimulus(0, 148, 1, 1'b0);
    applyStimulus(1, 0, 2, 1'b0);
    applyStimulus(0, 197, 1, 1'b0);
    // React presses are ignored once the round is decided.
    reactBtn = 2'b10;
    repeat (4) @(negedge clk);
    reactBtn = '0;
    repeat (6) @(negedge clk);
    checkOutput("doneIgnoresReact", int'(winner), 1);
    checkOutput("doneLedOff", int'(led), 0);
    applyStimulus(0, 77, 2, 1'b1);
    applyStimulus(0, $urandom_range(20, 120), 3, 1'b0);

    for (int r = 0; r < 12; r++) begin
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 300)),
                    int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
    end

    applyStimulus(2, 0, 0, 1'b0);

    // Asynchronous reset in the middle of GO, away from any clock edge.
    @(negedge clk);
    startBtn = 1'b1;
    repeat (3) @(negedge clk);
    startBtn = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
        @(negedge clk);
        if (led) ok = 1'b1;
      end
      checkOutput("rstRoundLed", int'(ok), 1);
    end
    repeat (20) @(negedge clk);
    monitorEn = 1'b0;
    @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midRstLed", int'(led), 0);
    checkOutput("midRstWinner", int'(winner), 0);
    checkOutput("midRstFalseStart", int'(falseStart), 0);
    checkOutput("midRstSeg", int'(seg), int'(7'b1000000));
    checkOutput("midRstAn", int'(an), int'(4'b1110));
    modelBest = 9999;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("postRstLed", int'(led), 0);
    readDisplay(v);
    checkOutput("postRstIdle", v, 0);
    showBest = 1'b1;
    repeat (2) @(negedge clk);
    readDisplay(v);
    checkOutput("postRstBest", v, modelBest);
    showBest = 1'b0;

    checkOutput("scoreboardDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
